// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
// A single full-subtractor cell and a borrow flop; chains through bin/bout for multi-word use.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_ovf      = (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // The operand MSBs are kept separately because the shift registers lose them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        diff <= w_res_next;
                        bout <= w_br_next;
                        ovf  <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit and a 1-bit instance checked
// against an arithmetic reference model.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic [7:0] diff8;
  logic       bout8, ovf8, busy8, done8;
  logic [1:0] st8;

  logic       start1, bin1;
  logic [0:0] a1, b1;
  logic [0:0] diff1;
  logic       bout1, ovf1, busy1, done1;
  logic [1:0] st1;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8), .done(done8),
    .dbg_state(st8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .diff(diff1), .bout(bout1), .ovf(ovf1), .busy(busy1), .done(done1),
    .dbg_state(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: unsigned subtraction one bit wider gives the borrow
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic bn,
                       output logic [63:0] d, output logic bo, output logic ov);
    logic [64:0] full;
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    full = {1'b0, a & mask} - {1'b0, b & mask} - {64'd0, bn};
    d    = full[63:0] & mask;
    bo   = full[w];
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
  endtask

  // one 8-bit operation; disturb=1 toggles start and operands while in flight
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bn,
                     input bit disturb);
    logic [63:0] ed;
    logic        eb, eo;
    int          busy_cnt, n;
    model(8, {56'd0, a}, {56'd0, b}, bn, ed, eb, eo);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bn; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    busy_cnt = 0;
    n = 0;
    while (!done8 && n < 40) begin
      if (busy8) busy_cnt++;
      if (disturb) begin
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        bin8 = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done8, 1'b1);
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_busy_in_done"}, busy8, 1'b0);
    chk({tag, "_diff"}, diff8, ed[7:0]);
    chk({tag, "_bout"}, bout8, eb);
    chk({tag, "_ovf"}, ovf8, eo);
    // start held through the DONE cycle must not be accepted
    start8 = disturb;
    @(negedge clk);
    start8 = 1'b0;
    chk({tag, "_done_one_cycle"}, done8, 1'b0);
    chk({tag, "_idle_after_done"}, busy8, 1'b0);
  endtask

  task automatic op1(input string tag, input logic a, input logic b, input logic bn);
    logic [63:0] ed;
    logic        eb, eo;
    int          n;
    model(1, {63'd0, a}, {63'd0, b}, bn, ed, eb, eo);
    @(negedge clk);
    a1 = a; b1 = b; bin1 = bn; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk({tag, "_busy"}, busy1, 1'b1);
    n = 0;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_diff"}, diff1, ed[0:0]);
    chk({tag, "_bout"}, bout1, eb);
    chk({tag, "_ovf"}, ovf1, eo);
    @(negedge clk);
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_fail   = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; bin1 = 0;
    rst = 1'b1;
    #1;
    chk("rst_diff", diff8, 8'h00);
    chk("rst_bout", bout8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_state", st8, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    op8("sub_5a_3c", 8'h5A, 8'h3C, 1'b0, 0);
    chk("plan_5a_3c", diff8, 8'h1E);
    op8("sub_00_01", 8'h00, 8'h01, 1'b0, 0);
    op8("sub_10_10_bin", 8'h10, 8'h10, 1'b1, 0);
    chk("plan_10_10_bin", {bout8, diff8}, 9'h1FF);
    op8("sub_80_01", 8'h80, 8'h01, 1'b0, 0);
    chk("plan_80_01_ovf", ovf8, 1'b1);
    op8("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 0);
    op8("sub_ff_ff_bin", 8'hFF, 8'hFF, 1'b1, 0);

    // randomized operands
    for (int i = 0; i < 16; i++) begin
      op8("rand", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    end

    // start and operand changes while busy
    for (int i = 0; i < 3; i++) begin
      op8("disturb", 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);
    end

    // WIDTH=1 truth table
    for (int v = 0; v < 8; v++) begin
      logic [2:0] bits;
      bits = 3'(v);
      op1("w1", bits[2], bits[1], bits[0]);
    end

    // reset after three bits of an operation in flight
    op8("pre_rst", 8'h7F, 8'hFF, 1'b0, 0);
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_diff", diff8, 8'h00);
    chk("midrst_bout", bout8, 1'b0);
    chk("midrst_ovf", ovf8, 1'b0);
    chk("midrst_busy", busy8, 1'b0);
    chk("midrst_done", done8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 || busy8) dones++;
    end
    chk("midrst_no_done", dones, 0);
    op8("post_rst", 8'h05, 8'h03, 1'b0, 0);
    chk("plan_post_rst", diff8, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
